core_sequencer: RTL
===================

# core_sequencer

Instruction sequencer for the core. It generates the 50-bit `inst` word that runs one complete weight-stationary tile:

1. load the weight rows from XMEM port 0 into L0, then into the PE array;
2. stream `n_act` activation vectors through the array;
3. drain every OFIFO output vector into PMEM.

It sits between the host/testbench and the core's `inst` input, and uses `l0_ready` and `ofifo_valid` from the core as flow control.

## Interface
Parameters:
- `row`, 8: PE array rows.
- `col`, 8: PE array columns, which is also the number of weight vectors loaded.
- `xa_bw`, 11: XMEM address width.
- `pa_bw`, 14: PMEM address width.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a tile. Sampled only in IDLE.
- `w_base`  in  xa_bw: XMEM address of weight vector 0.
- `a_base`  in  xa_bw: XMEM address of activation vector 0.
- `n_act`  in  xa_bw: number of activation vectors, 0..L0 depth.
- `p_base`  in  pa_bw: PMEM address for output vector 0.
- `l0_ready`  in  1: L0 can accept a write.
- `ofifo_valid`  in  1: OFIFO holds a readable vector.
- `inst`  out  50: core instruction word, registered.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the tile completes.

## Operation
- All of `start`, `w_base`, `a_base`, `n_act` and `p_base` are latched on the accepted `start`. Inputs are ignored while busy.
- IDLE word (also the reset value of `inst`):
  - `inst[48]`=1, `inst[47]`=1, `inst[32]`=1, `inst[20]`=1, `inst[19]`=1;
  - all other bits 0.
- Fields not named in a state keep their IDLE value. The following are constant 0 in every state: `inst[2]` (mode), `inst[5]`, `inst[6]`, `inst[49]`.
- States: IDLE → WREAD → WKERNEL → WFLUSH → AREAD → EXEC → DRAIN → DONE → IDLE.
- **WREAD**
  - XMEM read k: `inst[20]`=0, `inst[19]`=1, `inst[18:8]`=`w_base`+k (mod 2^xa_bw).
  - A read is issued only in a cycle where `l0_ready`=1.
  - `inst[3]` (l0_wr) is asserted in the cycle after each read, unconditionally. L0 deasserts `l0_ready` with at least one free slot remaining.
  - The state exits after the `col`-th l0_wr.
- **WKERNEL**: `inst[4]`=1 and `inst[0]`=1 for exactly `col` cycles.
- **WFLUSH**: IDLE word for `row`+`col` cycles.
- **AREAD**
  - Same read/write scheme as WREAD, using `a_base` and `n_act` vectors.
  - If `n_act`=0, WFLUSH exits directly to DONE.
- **EXEC**: `inst[4]`=1 and `inst[1]`=1 for exactly `n_act` cycles.
- **DRAIN**
  - In any cycle with `ofifo_valid`=1 and fewer than `n_act` reads issued, assert `inst[7]`.
  - In the following cycle, write PMEM: `inst[48]`=0, `inst[47]`=0, `inst[46:33]`=`p_base`+j (mod 2^pa_bw), where j counts the writes.
  - The state exits after write `n_act` completes. No timeout.
- **DONE**: IDLE word and `done`=1 for one cycle, then IDLE.
- Reset asserted at any time: `inst` is forced to the IDLE word immediately, with `busy`=0, `done`=0 and all counters 0. In-flight operations are abandoned and no partial tile resumes.
- `start` asserted in the DONE cycle is ignored. It is accepted from IDLE one cycle later.

## Timing
- The `start` sampled at edge 0 makes the FSM enter WREAD in cycle 1.
- With `l0_ready`=1 throughout and `col`=`row`=8:
  - XMEM reads in cycles 1–8; l0_wr in cycles 2–9.
  - WKERNEL 10–17; WFLUSH 18–33.
  - AREAD reads 34..33+n; l0_wr 35..34+n.
  - EXEC 35+n..34+2n.
  - DRAIN from 35+2n.
- Each `l0_ready`=0 cycle delays the remaining reads by one cycle. A write already in flight still completes.
- DRAIN at full rate (`ofifo_valid` held high) is one vector per cycle. The first PMEM write is one cycle after the first `inst[7]`.
- `done` rises the cycle after the last PMEM write.
- `busy` rises the cycle after `start` is accepted and falls with DONE's exit.

## Test plan
- Reset: hold `reset`=0 → `inst`=0x1_8001_0018_0000 (IDLE word), `busy`=0, `done`=0. Release; keep `start`=0 → no change for 20 cycles.
- Nominal tile: `w_base`=0, `a_base`=16, `n_act`=4, `p_base`=100, `l0_ready`=1, `ofifo_valid`=1 → expect:
  - reads A0=0..7 in cycles 1–8;
  - load in cycles 10–17;
  - reads A0=16..19 in cycles 34–37;
  - execute in cycles 39–42;
  - PMEM writes A=100..103 in cycles 44–47;
  - `done` in cycle 48.
- Backpressure: drop `l0_ready` for 3 cycles after the 2nd weight read → exactly 8 l0_wr pulses total, addresses contiguous, WKERNEL starts 3 cycles late.
- Sparse drain: `ofifo_valid` high on alternate cycles → exactly `n_act` `ofifo_rd` pulses, each followed next cycle by a write to consecutive PMEM addresses; `done` follows the last write.
- Boundaries:
  - `n_act`=0 → DONE directly after WFLUSH, with no execute or PMEM write.
  - `w_base`=2044 → read addresses wrap 2044..2047, 0..3.
- Reset mid-EXEC → IDLE word on the same edge as reset assertion. A new `start` after release runs a complete tile from WREAD.

Source files
------------

// File: rtl/core_sequencer.sv
// Weight-stationary tile sequencer: emits the registered 50-bit core instruction word
// that loads weights, streams activations and drains OFIFO results into PMEM.
//
// state     | meaning
// S_IDLE    | waiting for start, IDLE word on inst
// S_WREAD   | XMEM weight reads into L0, gated by l0_ready
// S_WKERNEL | L0 -> PE array weight load, col cycles
// S_WFLUSH  | IDLE word for row+col cycles
// S_AREAD   | XMEM activation reads into L0, gated by l0_ready
// S_EXEC    | activation streaming, n_act cycles
// S_DRAIN   | OFIFO reads, each followed by a PMEM write
// S_DONE    | one-cycle done pulse
module core_sequencer #(
    parameter int row   = 8,
    parameter int col   = 8,
    parameter int xa_bw = 11,
    parameter int pa_bw = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [xa_bw-1:0] w_base,
    input  logic [xa_bw-1:0] a_base,
    input  logic [xa_bw-1:0] n_act,
    input  logic [pa_bw-1:0] p_base,
    input  logic             l0_ready,
    input  logic             ofifo_valid,
    output logic [49:0]      inst,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREAD,
        S_WKERNEL,
        S_WFLUSH,
        S_AREAD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int CW = xa_bw + 1;
    localparam logic [CW-1:0] COL_C      = CW'(col);
    localparam logic [CW-1:0] KERN_LAST  = CW'(col - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(row + col - 1);
    localparam logic [49:0]   IDLE_WORD  = 50'h1_8001_0018_0000;

    localparam int B_KERNEL = 0;
    localparam int B_EXEC   = 1;
    localparam int B_L0WR   = 3;
    localparam int B_LOAD   = 4;
    localparam int B_OFRD   = 7;
    localparam int B_XWEN   = 19;
    localparam int B_XCEN   = 20;
    localparam int B_PWEN   = 47;
    localparam int B_PCEN   = 48;

    state_t             state_q, state_d;
    logic [49:0]        inst_q, inst_d;
    logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]      tmr_q, tmr_d;
    logic [xa_bw-1:0]   w_base_q, w_base_d;
    logic [xa_bw-1:0]   a_base_q, a_base_d;
    logic [xa_bw-1:0]   n_act_q, n_act_d;
    logic [pa_bw-1:0]   p_base_q, p_base_d;

    logic [CW-1:0]      n_act_ext;
    logic [xa_bw-1:0]   rd_base;
    logic [CW-1:0]      rd_tgt;

    assign n_act_ext = {1'b0, n_act_q};

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        tmr_d    = tmr_q;
        w_base_d = w_base_q;
        a_base_d = a_base_q;
        n_act_d  = n_act_q;
        p_base_d = p_base_q;
        inst_d   = IDLE_WORD;
        rd_base  = a_base_q;
        rd_tgt   = n_act_ext;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_base_d = w_base;
                    a_base_d = a_base;
                    n_act_d  = n_act;
                    p_base_d = p_base;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    state_d  = S_WREAD;
                end
            end
            S_WREAD, S_AREAD: begin
                if (inst_q[B_L0WR]) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (state_q == S_WREAD && wr_cnt_d == COL_C) begin
                        state_d = S_WKERNEL;
                        tmr_d   = KERN_LAST;
                    end else if (state_q == S_AREAD && wr_cnt_d == n_act_ext) begin
                        state_d = S_EXEC;
                        tmr_d   = n_act_ext - CW'(1);
                    end
                end
            end
            S_WKERNEL: begin
                if (tmr_q == '0) begin
                    state_d = S_WFLUSH;
                    tmr_d   = FLUSH_LAST;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            S_WFLUSH: begin
                if (tmr_q == '0) begin
                    state_d  = (n_act_q == '0) ? S_DONE : S_AREAD;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            S_EXEC: begin
                if (tmr_q == '0) begin
                    state_d  = S_DRAIN;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            S_DRAIN: begin
                if (!inst_q[B_PCEN]) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_d == n_act_ext) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // inst is registered, so the word is built for the state being entered
        case (state_d)
            S_WREAD, S_AREAD: begin
                inst_d[B_L0WR] = ~inst_q[B_XCEN];
                rd_base = (state_d == S_WREAD) ? w_base_d : a_base_q;
                rd_tgt  = (state_d == S_WREAD) ? COL_C : n_act_ext;
                if (l0_ready && (rd_cnt_d < rd_tgt)) begin
                    inst_d[B_XCEN] = 1'b0;
                    inst_d[B_XWEN] = 1'b1;
                    inst_d[18:8]   = rd_base + rd_cnt_d[xa_bw-1:0];
                    rd_cnt_d       = rd_cnt_d + CW'(1);
                end
            end
            S_WKERNEL: begin
                inst_d[B_LOAD]   = 1'b1;
                inst_d[B_KERNEL] = 1'b1;
            end
            S_EXEC: begin
                inst_d[B_LOAD] = 1'b1;
                inst_d[B_EXEC] = 1'b1;
            end
            S_DRAIN: begin
                if (inst_q[B_OFRD]) begin
                    inst_d[B_PCEN]  = 1'b0;
                    inst_d[B_PWEN]  = 1'b0;
                    inst_d[46:33]   = p_base_q + pa_bw'(wr_cnt_d);
                end
                if (ofifo_valid && (rd_cnt_d < n_act_ext)) begin
                    inst_d[B_OFRD] = 1'b1;
                    rd_cnt_d       = rd_cnt_d + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            inst_q   <= IDLE_WORD;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            tmr_q    <= '0;
            w_base_q <= '0;
            a_base_q <= '0;
            n_act_q  <= '0;
            p_base_q <= '0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            tmr_q    <= tmr_d;
            w_base_q <= w_base_d;
            a_base_q <= a_base_d;
            n_act_q  <= n_act_d;
            p_base_q <= p_base_d;
        end
    end

    assign inst = inst_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule
